store_rmw: RTL and testbench
============================

// Module: store_rmw
// PURPOSE
//  Store-path counterpart to the load extender: takes SB/SH/SW requests from the datapath.
//  Drives a word-wide data memory that has no byte enables.
//  SW: direct word write. SB/SH: read-modify-write (read word, merge lane(s), write back).
//  Sits between the execute stage and data memory; flags misaligned/illegal/timeout stores.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles spent in RWAIT for MemRValid before aborting (1..255)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   reset, asynchronous, active-low
//  StoreValid  in   1   store request valid
//  StoreReady  out  1   request accepted when StoreValid&&StoreReady; =1 only in IDLE
//  Addr        in   32  byte address
//  WriteData   in   32  store data, LSB-justified (rs2)
//  LdStrSrc    in   3   funct3: 000 SB, 001 SH, 010 SW; others illegal
//  StoreDone   out  1   one-cycle pulse, store committed
//  StoreErr    out  1   one-cycle pulse, store aborted, memory untouched
//  ErrCode     out  2   valid with StoreErr: 01 misaligned, 10 timeout, 11 illegal funct3
//  MemAddr     out  32  {Addr_q[31:2],2'b00}, stable from accept until RESP
//  MemRE       out  1   one-cycle read strobe (RREQ state)
//  MemRData    in   32  read word
//  MemRValid   in   1   read data valid; sampled only in RWAIT (memory latency >=1)
//  MemWE       out  1   write request, held until MemWReady
//  MemWData    out  32  merged write word, valid while MemWE
//  MemWReady   in   1   write accepted this cycle
// BEHAVIOUR
//  States: IDLE, RREQ, RWAIT, WREQ, RESP. All outputs decode from registered state/regs.
//  Reset (rst_n=0, any state, async): state=IDLE, StoreReady=1, all other outputs 0,
//   captured regs and timeout counter cleared. In-flight store is dropped, no Done/Err.
//  IDLE: on accept, latch Addr/WriteData/LdStrSrc. Checks, in priority order:
//   illegal funct3 -> RESP err 11; SH with Addr[0]=1 or SW with Addr[1:0]!=0 -> RESP err 01;
//   SW -> WREQ (MemWData=WriteData); SB/SH -> RREQ.
//  RREQ: MemRE=1 one cycle -> RWAIT, counter cleared to 0.
//  RWAIT: MemRValid=1 -> latch merged word, go to WREQ (even if counter==TIMEOUT_CYC
//   that cycle; data wins). Otherwise counter++. Reaching TIMEOUT_CYC -> RESP err 10.
//  Merge, SB: lane Addr[1:0] <= WriteData[7:0], other lanes from MemRData.
//  Merge, SH: half Addr[1] <= WriteData[15:0], other half from MemRData.
//  WREQ: MemWE=1, MemWData stable; stay until MemWReady -> RESP ok.
//  RESP: exactly one cycle; StoreDone xor StoreErr =1; StoreReady=0; -> IDLE.
//  Latency (accept to StoreDone): SW = 2 + write wait cycles.
//   SB/SH = 4 + read latency-1 + write wait cycles (min 4 with 1-cycle read and
//   same-cycle write ack; accept in IDLE, RREQ, RWAIT, WREQ, RESP).
//  Back-to-back: next accept earliest in cycle after RESP. No outstanding overlap.
//  StoreValid while not ready: ignored, no buffering. Requester holds until accepted.
//  MemRValid outside RWAIT and MemWReady outside WREQ: ignored.
// STRUCTURE
//  lsu_pkg (shared with load path): LdStrSrc encodings (LS_B=3'b000, LS_H=3'b001,
//   LS_W=3'b010, LS_BU=3'b100, LS_HU=3'b101), store state enum, ErrCode enum.
//  Sub-module store_merge: combinational (MemRData, WriteData, ByteOffset, LdStrSrc) -> merged word.
//  FSM, capture regs and timeout counter stay in store_rmw.
// TESTING
//  1 SW Addr=0x100 WD=0xDEADBEEF, MemWReady same cycle -> no MemRE; MemWE with
//    MemAddr=0x100, MemWData=0xDEADBEEF; StoreDone 2 cycles after accept.
//  2 SB Addr=0x103 WD=0x000000AB, MemRData=0x11223344 after 3 cycles ->
//    MemAddr=0x100, MemWData=0xAB223344, one StoreDone.
//  3 SH Addr=0x202 WD=0x1234CAFE, MemRData=0x11223344 -> MemWData=0xCAFE3344.
//    Repeat at Addr=0x200 -> MemWData=0x1122CAFE.
//  4 SH Addr=0x201 -> StoreErr ErrCode=01, MemRE/MemWE never high.
//    LdStrSrc=3'b011 -> ErrCode=11.
//  5 SB with MemRValid held 0, TIMEOUT_CYC=8 -> StoreErr ErrCode=10 after 8 RWAIT cycles,
//    no MemWE. Variant: MemRValid on 8th cycle -> write proceeds.
//  6 rst_n low mid-WREQ (MemWReady=0) -> MemWE=0 immediately (async), StoreReady=1,
//    no Done/Err; next SW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: funct3 encodings, store FSM states and store error codes.
package lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RREQ,
    ST_RWAIT,
    ST_WREQ,
    ST_RESP
  } store_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } store_err_e;

  // The unsigned load encodings share funct3 space but have no store meaning.
  function automatic logic is_store_op(input logic [2:0] funct);
    return (funct == LS_B) || (funct == LS_H) || (funct == LS_W);
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: overlays the byte/half being stored onto the word read back from memory.
module store_merge
  import lsu_pkg::*;
(
  input  logic [31:0] MemRData,
  input  logic [31:0] WriteData,
  input  logic [1:0]  ByteOffset,
  input  logic [2:0]  LdStrSrc,
  output logic [31:0] MergedData
);

  always_comb begin
    MergedData = MemRData;
    if (LdStrSrc == LS_W) begin
      MergedData = WriteData;
    end else if (LdStrSrc == LS_H) begin
      if (ByteOffset[1]) MergedData[31:16] = WriteData[15:0];
      else               MergedData[15:0]  = WriteData[15:0];
    end else begin
      case (ByteOffset)
        2'd0:    MergedData[7:0]   = WriteData[7:0];
        2'd1:    MergedData[15:8]  = WriteData[7:0];
        2'd2:    MergedData[23:16] = WriteData[7:0];
        default: MergedData[31:24] = WriteData[7:0];
      endcase
    end
  end

endmodule

// File: rtl/store_rmw.sv
// Store path to a word-only data memory: SW writes directly, SB/SH do read-merge-write.
// Misaligned, illegal-funct3 and read-timeout stores abort without touching memory.
module store_rmw
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StoreValid,
  output logic        StoreReady,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [2:0]  LdStrSrc,
  output logic        StoreDone,
  output logic        StoreErr,
  output logic [1:0]  ErrCode,
  output logic [31:0] MemAddr,
  output logic        MemRE,
  input  logic [31:0] MemRData,
  input  logic        MemRValid,
  output logic        MemWE,
  output logic [31:0] MemWData,
  input  logic        MemWReady
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

  store_state_e state, state_n;
  store_err_e   err_q, err_n;
  logic [31:0]  addr_q, addr_n;
  logic [31:0]  data_q, data_n;
  logic [31:0]  wdata_q, wdata_n;
  logic [2:0]   funct_q, funct_n;
  logic [7:0]   cnt_q, cnt_n;
  logic [31:0]  merged;

  store_merge u_merge (
    .MemRData   (MemRData),
    .WriteData  (data_q),
    .ByteOffset (addr_q[1:0]),
    .LdStrSrc   (funct_q),
    .MergedData (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      err_q   <= ERR_NONE;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      funct_q <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      err_q   <= err_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      wdata_q <= wdata_n;
      funct_q <= funct_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    err_n   = err_q;
    addr_n  = addr_q;
    data_n  = data_q;
    wdata_n = wdata_q;
    funct_n = funct_q;
    cnt_n   = cnt_q;
    case (state)
      ST_IDLE: begin
        if (StoreValid) begin
          addr_n  = Addr;
          data_n  = WriteData;
          funct_n = LdStrSrc;
          err_n   = ERR_NONE;
          if (!is_store_op(LdStrSrc)) begin
            err_n   = ERR_ILLEGAL;
            state_n = ST_RESP;
          end else if ((LdStrSrc == LS_H && Addr[0]) ||
                       (LdStrSrc == LS_W && Addr[1:0] != 2'b00)) begin
            err_n   = ERR_MISALIGN;
            state_n = ST_RESP;
          end else if (LdStrSrc == LS_W) begin
            wdata_n = WriteData;
            state_n = ST_WREQ;
          end else begin
            state_n = ST_RREQ;
          end
        end
      end
      ST_RREQ: begin
        cnt_n   = '0;
        state_n = ST_RWAIT;
      end
      // Read data arriving in the same cycle the budget runs out still wins.
      ST_RWAIT: begin
        if (MemRValid) begin
          wdata_n = merged;
          state_n = ST_WREQ;
        end else begin
          cnt_n = cnt_q + 8'd1;
          if (cnt_n == TMO) begin
            err_n   = ERR_TIMEOUT;
            state_n = ST_RESP;
          end
        end
      end
      ST_WREQ: begin
        if (MemWReady) state_n = ST_RESP;
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign StoreReady = (state == ST_IDLE);
  assign MemRE      = (state == ST_RREQ);
  assign MemWE      = (state == ST_WREQ);
  assign MemWData   = (state == ST_WREQ) ? wdata_q : '0;
  assign MemAddr    = {addr_q[31:2], 2'b00};
  assign StoreDone  = (state == ST_RESP) && (err_q == ERR_NONE);
  assign StoreErr   = (state == ST_RESP) && (err_q != ERR_NONE);
  assign ErrCode    = (state == ST_RESP) ? err_q : ERR_NONE;

endmodule

// File: tb/tb_store_rmw.sv
// Directed bench for store_rmw: scripted memory responder plus write/response scoreboards.
module tb_store_rmw;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StoreValid;
  logic        StoreReady;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [2:0]  LdStrSrc;
  logic        StoreDone;
  logic        StoreErr;
  logic [1:0]  ErrCode;
  logic [31:0] MemAddr;
  logic        MemRE;
  logic [31:0] MemRData;
  logic        MemRValid;
  logic        MemWE;
  logic [31:0] MemWData;
  logic        MemWReady;

  always #5 clk = ~clk;

  store_rmw #(.TIMEOUT_CYC(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StoreValid (StoreValid),
    .StoreReady (StoreReady),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .LdStrSrc   (LdStrSrc),
    .StoreDone  (StoreDone),
    .StoreErr   (StoreErr),
    .ErrCode    (ErrCode),
    .MemAddr    (MemAddr),
    .MemRE      (MemRE),
    .MemRData   (MemRData),
    .MemRValid  (MemRValid),
    .MemWE      (MemWE),
    .MemWData   (MemWData),
    .MemWReady  (MemWReady)
  );

  typedef struct {
    logic       err;
    logic [1:0] code;
    int         lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t       resp_q[$];
  wr_t         wr_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rd_cnt = -1;
  int          rd_lat = 1;
  bit          rd_never = 1'b0;
  logic [31:0] rd_word = '0;
  bit          seen_re = 1'b0;
  bit          seen_we = 1'b0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: runs at the falling edge, away from the DUT's active edge.
  task automatic checkOutput();
    resp_t r;
    wr_t   w;
    if (MemRE) seen_re = 1'b1;
    if (MemWE) seen_we = 1'b1;
    if (MemWE && MemWReady) begin
      cmp("write_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        cmp("mem_addr", MemAddr, w.addr);
        cmp("mem_wdata", MemWData, w.data);
      end
    end
    if (StoreDone || StoreErr) begin
      cmp("resp_expected", 32'(resp_q.size() != 0), 32'd1);
      if (resp_q.size() != 0) begin
        r = resp_q.pop_front();
        cmp("store_done", 32'(StoreDone), 32'(!r.err));
        cmp("store_err", 32'(StoreErr), 32'(r.err));
        cmp("err_code", 32'(ErrCode), 32'(r.code));
        if (r.lat >= 0) cmp("latency", 32'(cyc - acc_cyc), 32'(r.lat));
      end
    end
  endtask

  // One clock: check at negedge, then drive next-cycle inputs just after posedge.
  task automatic tick();
    bit acc;
    @(negedge clk);
    cyc++;
    checkOutput();
    acc = StoreValid && StoreReady && rst_n;
    if (acc) acc_cyc = cyc;
    if (MemRE && !rd_never) rd_cnt = rd_lat;
    @(posedge clk);
    #1;
    if (acc) StoreValid = 1'b0;
    MemRValid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        MemRValid = 1'b1;
        MemRData  = rd_word;
        rd_cnt    = -1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f,
                               input logic err, input logic [1:0] code, input int lat,
                               input bit do_write, input logic [31:0] waddr, input logic [31:0] wdata);
    resp_t r;
    wr_t   w;
    r.err = err; r.code = code; r.lat = lat;
    resp_q.push_back(r);
    if (do_write) begin
      w.addr = waddr; w.data = wdata;
      wr_q.push_back(w);
    end
    Addr = a; WriteData = wd; LdStrSrc = f; StoreValid = 1'b1;
    for (int i = 0; i < 50 && StoreValid; i++) tick();
    cmp("accept_bound", 32'(StoreValid), 32'd0);
    StoreValid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && resp_q.size() != 0; i++) tick();
    cmp("resp_bound", 32'(resp_q.size()), 32'd0);
    cmp("writes_drained", 32'(wr_q.size()), 32'd0);
    resp_q.delete();
    wr_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; StoreValid = 1'b0; Addr = '0; WriteData = '0; LdStrSrc = '0;
    MemRData = '0; MemRValid = 1'b0; MemWReady = 1'b1;
    #3;
    cmp("rst_ready", 32'(StoreReady), 32'd1);
    cmp("rst_done", 32'(StoreDone), 32'd0);
    cmp("rst_err", 32'(StoreErr), 32'd0);
    cmp("rst_code", 32'(ErrCode), 32'd0);
    cmp("rst_maddr", MemAddr, 32'd0);
    cmp("rst_re", 32'(MemRE), 32'd0);
    cmp("rst_we", 32'(MemWE), 32'd0);
    cmp("rst_wdata", MemWData, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    $display("[TB] SW direct write");
    seen_re = 1'b0;
    applyStimulus(32'h100, 32'hDEADBEEF, LS_W, 1'b0, 2'b00, 2, 1'b1, 32'h100, 32'hDEADBEEF);
    waitDone(20);
    cmp("sw_no_read", 32'(seen_re), 32'd0);

    $display("[TB] SB with 3-cycle read");
    rd_lat = 3; rd_word = 32'h11223344;
    applyStimulus(32'h103, 32'h000000AB, LS_B, 1'b0, 2'b00, 6, 1'b1, 32'h100, 32'hAB223344);
    waitDone(30);

    $display("[TB] SH upper and lower halves");
    rd_lat = 1;
    applyStimulus(32'h202, 32'h1234CAFE, LS_H, 1'b0, 2'b00, 4, 1'b1, 32'h200, 32'hCAFE3344);
    waitDone(30);
    applyStimulus(32'h200, 32'h1234CAFE, LS_H, 1'b0, 2'b00, 4, 1'b1, 32'h200, 32'h1122CAFE);
    waitDone(30);

    $display("[TB] misaligned and illegal stores");
    seen_re = 1'b0; seen_we = 1'b0;
    applyStimulus(32'h201, 32'h5555AAAA, LS_H, 1'b1, 2'b01, 1, 1'b0, '0, '0);
    waitDone(10);
    applyStimulus(32'h102, 32'h5555AAAA, LS_W, 1'b1, 2'b01, 1, 1'b0, '0, '0);
    waitDone(10);
    applyStimulus(32'h300, 32'h5555AAAA, 3'b011, 1'b1, 2'b11, 1, 1'b0, '0, '0);
    waitDone(10);
    applyStimulus(32'h201, 32'h5555AAAA, LS_HU, 1'b1, 2'b11, 1, 1'b0, '0, '0);
    waitDone(10);
    cmp("err_no_read", 32'(seen_re), 32'd0);
    cmp("err_no_write", 32'(seen_we), 32'd0);

    $display("[TB] read timeout and last-cycle data");
    seen_we = 1'b0; rd_never = 1'b1;
    applyStimulus(32'h104, 32'h00000055, LS_B, 1'b1, 2'b10, 10, 1'b0, '0, '0);
    waitDone(40);
    cmp("tmo_no_write", 32'(seen_we), 32'd0);
    rd_never = 1'b0; rd_lat = 8; rd_word = 32'hAABBCCDD;
    applyStimulus(32'h105, 32'h00000077, LS_B, 1'b0, 2'b00, 11, 1'b1, 32'h104, 32'hAABB77DD);
    waitDone(40);

    $display("[TB] async reset during write wait");
    MemWReady = 1'b0;
    Addr = 32'h400; WriteData = 32'h12345678; LdStrSrc = LS_W; StoreValid = 1'b1;
    for (int i = 0; i < 10 && !MemWE; i++) tick();
    cmp("wreq_reached", 32'(MemWE), 32'd1);
    StoreValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_we", 32'(MemWE), 32'd0);
    cmp("arst_ready", 32'(StoreReady), 32'd1);
    cmp("arst_wdata", MemWData, 32'd0);
    rd_cnt = -1;
    tick();
    tick();
    rst_n = 1'b1;
    MemWReady = 1'b1;
    applyStimulus(32'h404, 32'hCAFEF00D, LS_W, 1'b0, 2'b00, 2, 1'b1, 32'h404, 32'hCAFEF00D);
    waitDone(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
